// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between two requesters.
// Operands are registered into the ALU; the result is returned under valid/ready.
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [2:0]      req_op0,
  input  logic [2:0]      req_op1,
  input  logic [7:0]      req_a0,
  input  logic [7:0]      req_a1,
  input  logic [7:0]      req_b0,
  input  logic [7:0]      req_b1,
  output logic [NREQ-1:0] resp_valid,
  input  logic [NREQ-1:0] resp_ready,
  output logic [7:0]      resp_data,
  output logic            resp_jump,
  output logic [2:0]      alu_op,
  output logic [7:0]      alu_in1,
  output logic [7:0]      alu_in2,
  input  logic [7:0]      alu_out,
  input  logic            alu_jump,
  output logic            owner
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e     state_q;
  logic       prio_q;
  logic       owner_q;
  logic [2:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] data_q;
  logic       jump_q;

  logic       gnt;
  logic       accept;
  logic       hs;
  logic [2:0] op_sel;
  logic [7:0] a_sel;
  logic [7:0] b_sel;

  // Contention falls back to the pointer; a lone request wins outright.
  always_comb begin
    gnt    = (&req_valid) ? prio_q : req_valid[1];
    accept = (state_q == IDLE) && (|req_valid) && !reset;
    hs     = (state_q == RESP) &&
             (owner_q ? resp_ready[1] : resp_ready[0]);
    op_sel = gnt ? req_op1 : req_op0;
    a_sel  = gnt ? req_a1  : req_a0;
    b_sel  = gnt ? req_b1  : req_b0;
  end

  assign req_ready  = accept ? {gnt, ~gnt} : '0;
  assign resp_valid = (state_q == RESP) ? {owner_q, ~owner_q} : '0;
  assign resp_data  = data_q;
  assign resp_jump  = jump_q;
  assign owner      = owner_q;

  // The ALU sees operands only during its single execute cycle.
  assign alu_op  = (state_q == EXEC) ? op_q : 3'd0;
  assign alu_in1 = (state_q == EXEC) ? a_q  : 8'd0;
  assign alu_in2 = (state_q == EXEC) ? b_q  : 8'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      op_q    <= 3'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      data_q  <= 8'd0;
      jump_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= op_sel;
            a_q     <= a_sel;
            b_q     <= b_sel;
            owner_q <= gnt;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          data_q  <= alu_out;
          jump_q  <= alu_jump;
          state_q <= RESP;
        end
        RESP: begin
          if (hs) begin
            prio_q  <= ~owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* pins.
// Opcodes: ADD=0 XOR=1 AND=2 RSL=3 MOV=4 LD=5 ST=6 BLQZ=7.
module tb_alu_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] req_op0, req_op1;
  logic [7:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0] resp_valid;
  logic [1:0] resp_ready;
  logic [7:0] resp_data;
  logic       resp_jump;
  logic [2:0] alu_op;
  logic [7:0] alu_in1, alu_in2;
  logic [7:0] alu_out;
  logic       alu_jump;
  logic       owner;

  int tests;
  int fails;

  alu_arbiter #(.NREQ(2)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op0(req_op0),
    .req_op1(req_op1),
    .req_a0(req_a0),
    .req_a1(req_a1),
    .req_b0(req_b0),
    .req_b1(req_b1),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_jump(resp_jump),
    .alu_op(alu_op),
    .alu_in1(alu_in1),
    .alu_in2(alu_in2),
    .alu_out(alu_out),
    .alu_jump(alu_jump),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; BLQZ passes input2 and jumps when input1 <= 0 (signed).
  logic [15:0] rot;
  always_comb begin
    alu_out  = 8'd0;
    alu_jump = 1'b0;
    rot      = {alu_in1, alu_in1} << alu_in2[2:0];
    case (alu_op)
      3'd0: alu_out = alu_in1 + alu_in2;
      3'd1: alu_out = alu_in1 ^ alu_in2;
      3'd2: alu_out = alu_in1 & alu_in2;
      3'd3: alu_out = rot[15:8];
      3'd7: begin
        alu_out  = alu_in2;
        alu_jump = (alu_in1 == 8'd0) || alu_in1[7];
      end
      default: alu_out = 8'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [1:0] grants[$];
  logic [1:0] rports[$];
  logic [7:0] rdata[$];
  int         seen;

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    req_op0 = 3'd0; req_op1 = 3'd0;
    req_a0  = 8'd0; req_a1  = 8'd0;
    req_b0  = 8'd0; req_b1  = 8'd0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_req_ready", 16'(req_ready), 16'h0);
    chk("rst_resp_valid", 16'(resp_valid), 16'h0);
    chk("rst_resp_data", 16'(resp_data), 16'h0);
    chk("rst_resp_jump", 16'(resp_jump), 16'h0);
    chk("rst_alu_op", 16'(alu_op), 16'h0);
    chk("rst_alu_in1", 16'(alu_in1), 16'h0);
    chk("rst_alu_in2", 16'(alu_in2), 16'h0);
    chk("rst_owner", 16'(owner), 16'h0);

    // Single ADD from requester 0
    req_valid = 2'b01;
    req_op0 = 3'd0; req_a0 = 8'h7F; req_b0 = 8'h01;
    #1;
    chk("add_req_ready", 16'(req_ready), 16'h1);
    step();
    req_valid = 2'b00;
    #1;
    chk("add_exec_in1", 16'(alu_in1), 16'h7F);
    chk("add_exec_in2", 16'(alu_in2), 16'h01);
    chk("add_exec_rv", 16'(resp_valid), 16'h0);
    chk("add_exec_rdy", 16'(req_ready), 16'h0);
    step();
    chk("add_resp_valid", 16'(resp_valid), 16'h1);
    chk("add_resp_data", 16'(resp_data), 16'h80);
    chk("add_resp_jump", 16'(resp_jump), 16'h0);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    chk("add_done_rv", 16'(resp_valid), 16'h0);

    // BLQZ from requester 1, a=0 jumps
    req_valid = 2'b10;
    req_op1 = 3'd7; req_a1 = 8'h00; req_b1 = 8'h25;
    #1;
    chk("blqz0_req_ready", 16'(req_ready), 16'h2);
    step();
    req_valid = 2'b00;
    chk("blqz0_alu_op", 16'(alu_op), 16'h7);
    chk("blqz0_owner", 16'(owner), 16'h1);
    step();
    chk("blqz0_resp_valid", 16'(resp_valid), 16'h2);
    chk("blqz0_resp_data", 16'(resp_data), 16'h25);
    chk("blqz0_resp_jump", 16'(resp_jump), 16'h1);
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;

    // BLQZ with a=5 does not jump
    req_valid = 2'b10;
    req_a1 = 8'h05;
    step();
    req_valid = 2'b00;
    step();
    chk("blqz5_resp_valid", 16'(resp_valid), 16'h2);
    chk("blqz5_resp_data", 16'(resp_data), 16'h25);
    chk("blqz5_resp_jump", 16'(resp_jump), 16'h0);
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;

    // Contention: both valid continuously, ready held high
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    req_op0 = 3'd1; req_a0 = 8'hF0; req_b0 = 8'h3C;
    req_op1 = 3'd2; req_a1 = 8'hF0; req_b1 = 8'h3C;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (req_ready != 2'b00) grants.push_back(req_ready);
      if (resp_valid != 2'b00) begin
        rports.push_back(resp_valid);
        rdata.push_back(resp_data);
      end
      @(negedge clk);
    end
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    #1;
    seen = grants.size();
    chk("cont_grant_count", 16'(seen), 16'd4);
    seen = rports.size();
    chk("cont_resp_count", 16'(seen), 16'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < grants.size())
        chk($sformatf("cont_grant%0d", k), 16'(grants[k]),
            (k % 2 == 0) ? 16'h1 : 16'h2);
      if (k < rports.size()) begin
        chk($sformatf("cont_port%0d", k), 16'(rports[k]),
            (k % 2 == 0) ? 16'h1 : 16'h2);
        chk($sformatf("cont_data%0d", k), 16'(rdata[k]),
            (k % 2 == 0) ? 16'hCC : 16'h30);
      end
    end

    // Back-pressure on requester 0 with requester 1 waiting
    req_valid = 2'b01;
    req_op0 = 3'd0; req_a0 = 8'h10; req_b0 = 8'h20;
    #1;
    chk("bp_req_ready", 16'(req_ready), 16'h1);
    step();
    req_valid = 2'b10;
    req_op1 = 3'd1; req_a1 = 8'h0F; req_b1 = 8'hFF;
    step();
    resp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_rv%0d", k), 16'(resp_valid), 16'h1);
      chk($sformatf("bp_data%0d", k), 16'(resp_data), 16'h30);
      chk($sformatf("bp_rdy%0d", k), 16'(req_ready), 16'h0);
      @(negedge clk);
    end
    resp_ready = 2'b01;
    #1;
    chk("bp_hs_rv", 16'(resp_valid), 16'h1);
    step();
    resp_ready = 2'b00;
    chk("bp_r1_granted", 16'(req_ready), 16'h2);
    step();
    req_valid = 2'b00;
    step();
    chk("bp_r1_resp_valid", 16'(resp_valid), 16'h2);
    chk("bp_r1_resp_data", 16'(resp_data), 16'hF0);
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;

    // RSL: ALU pins active only during EXEC
    req_valid = 2'b01;
    req_op0 = 3'd3; req_a0 = 8'h81; req_b0 = 8'h01;
    #1;
    chk("rsl_idle_op", 16'(alu_op), 16'h0);
    chk("rsl_idle_in1", 16'(alu_in1), 16'h0);
    step();
    req_valid = 2'b00;
    chk("rsl_exec_op", 16'(alu_op), 16'h3);
    chk("rsl_exec_in1", 16'(alu_in1), 16'h81);
    chk("rsl_exec_in2", 16'(alu_in2), 16'h01);
    step();
    chk("rsl_resp_op", 16'(alu_op), 16'h0);
    chk("rsl_resp_in1", 16'(alu_in1), 16'h0);
    chk("rsl_resp_in2", 16'(alu_in2), 16'h0);
    chk("rsl_resp_data", 16'(resp_data), 16'h03);
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    chk("rsl_done_op", 16'(alu_op), 16'h0);

    // Reset during EXEC aborts; pointer returns to 0
    req_valid = 2'b01;
    req_op0 = 3'd0; req_a0 = 8'h11; req_b0 = 8'h22;
    step();
    req_valid = 2'b00;
    chk("abort_in_exec", 16'(alu_in1), 16'h11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_resp_valid", 16'(resp_valid), 16'h0);
    chk("abort_resp_data", 16'(resp_data), 16'h0);
    chk("abort_resp_jump", 16'(resp_jump), 16'h0);
    chk("abort_alu_op", 16'(alu_op), 16'h0);
    chk("abort_alu_in1", 16'(alu_in1), 16'h0);
    chk("abort_alu_in2", 16'(alu_in2), 16'h0);
    chk("abort_owner", 16'(owner), 16'h0);
    chk("abort_req_ready", 16'(req_ready), 16'h0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid != 2'b00) seen++;
      step();
    end
    chk("abort_no_resp", 16'(seen), 16'd0);
    req_valid = 2'b11;
    #1;
    chk("abort_prio0", 16'(req_ready), 16'h1);
    req_valid = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
